// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   run            1 = scan enabled, 0 = display dark
//   digit_data     packed hex digits, digit i = digit_data[4i+3:4i]
//   digit_mask     1 = digit i kept dark
//   dp_in          1 = decimal point lit on digit i
//   sel            digit index to the 3-to-8 decoder
//   en_n           decoder enable, active-low
//   seg_n          {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick     one-cycle pulse after the last digit's slot
module seg_scan_ctrl #(
    parameter int unsigned DIV          = 1000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned DIGITS       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] digit_data,
    input  logic [7:0]  digit_mask,
    input  logic [7:0]  dp_in,
    output logic [2:0]  sel,
    output logic        en_n,
    output logic [7:0]  seg_n,
    output logic        frame_tick
);

    localparam int unsigned CMAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      sel_d;
    logic            en_n_d;
    logic [7:0]      seg_n_d;
    logic            tick_d;
    logic [3:0]      nibble;

    // Hex to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] h);
        logic [6:0] c;
        case (h)
            4'h0: c = 7'h40;
            4'h1: c = 7'h79;
            4'h2: c = 7'h24;
            4'h3: c = 7'h30;
            4'h4: c = 7'h19;
            4'h5: c = 7'h12;
            4'h6: c = 7'h02;
            4'h7: c = 7'h78;
            4'h8: c = 7'h00;
            4'h9: c = 7'h10;
            4'hA: c = 7'h08;
            4'hB: c = 7'h03;
            4'hC: c = 7'h46;
            4'hD: c = 7'h21;
            4'hE: c = 7'h06;
            default: c = 7'h0E;
        endcase
        return c;
    endfunction

    assign nibble = digit_data[{sel, 2'b00} +: 4];

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sel_d   = sel;
        en_n_d  = en_n;
        seg_n_d = seg_n;
        tick_d  = 1'b0;
        case (state)
            IDLE: begin
                en_n_d  = 1'b1;
                seg_n_d = 8'hFF;
                sel_d   = 3'd0;
                cnt_d   = '0;
                if (run) begin
                    state_d = BLANK;
                end
            end
            BLANK: begin
                if (!run) begin
                    state_d = IDLE;
                    en_n_d  = 1'b1;
                    seg_n_d = 8'hFF;
                    sel_d   = 3'd0;
                    cnt_d   = '0;
                end else if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    // Latch the digit once so mid-slot input changes cannot tear it
                    state_d = SHOW;
                    cnt_d   = '0;
                    seg_n_d = {~dp_in[sel], seg_decode(nibble)};
                    en_n_d  = digit_mask[sel];
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            SHOW: begin
                if (!run) begin
                    state_d = IDLE;
                    en_n_d  = 1'b1;
                    seg_n_d = 8'hFF;
                    sel_d   = 3'd0;
                    cnt_d   = '0;
                end else if (cnt == CW'(DIV - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    en_n_d  = 1'b1;
                    seg_n_d = 8'hFF;
                    if (sel == 3'(DIGITS - 1)) begin
                        sel_d  = 3'd0;
                        tick_d = 1'b1;
                    end else begin
                        sel_d = sel + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                en_n_d  = 1'b1;
                seg_n_d = 8'hFF;
                sel_d   = 3'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 3'd0;
            en_n       <= 1'b1;
            seg_n      <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sel        <= sel_d;
            en_n       <= en_n_d;
            seg_n      <= seg_n_d;
            frame_tick <= tick_d;
        end
    end

endmodule
